// File: rtl/logit_accumulator_if.sv
// Handshake bundle between the logit source, the accumulator and the downstream argmax.
interface logit_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_WIDTH   = 16
) ();

  logic                    i_valid;
  logic                    i_ready;
  logic [3*IN_WIDTH-1:0]   i_data;
  logic                    i_clear;
  logic                    o_valid;
  logic                    o_ready;
  logic [3*DATA_WIDTH-1:0] o_logits;
  logic                    o_sat;

  modport master (
    output i_valid, i_data, i_clear, o_ready,
    input  i_ready, o_valid, o_logits, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_clear, o_ready,
    output i_ready, o_valid, o_logits, o_sat
  );

endinterface

// File: rtl/logit_accumulator.sv
// Sums NUM_STEPS beats of three signed per-class samples into saturating logits and
// holds each completed frame until downstream accepts it.
module logit_accumulator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned NUM_STEPS  = 8
) (
  input logic               clk,
  input logic               rst,
  logit_accumulator_if.slave bus
);

  localparam int unsigned CntW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(NUM_STEPS - 1);
  localparam logic [DATA_WIDTH-1:0] AccMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] AccMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e                     state_q, state_d;
  logic [2:0][DATA_WIDTH-1:0] acc_q, acc_d, acc_sum;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       sticky_q, sticky_d;
  logic [3*DATA_WIDTH-1:0]    logits_q, logits_d;
  logic                       osat_q, osat_d;
  logic                       sat_hit;

  // Saturating per-class add; one extra bit exposes overflow as a top-two-bit mismatch.
  always_comb begin
    logic [IN_WIDTH-1:0]   sample;
    logic [DATA_WIDTH:0]   sum;
    acc_sum = '0;
    sat_hit = 1'b0;
    sample  = '0;
    sum     = '0;
    for (int k = 0; k < 3; k++) begin
      sample = bus.i_data[k*IN_WIDTH +: IN_WIDTH];
      sum    = {acc_q[k][DATA_WIDTH-1], acc_q[k]} +
               {{(DATA_WIDTH+1-IN_WIDTH){sample[IN_WIDTH-1]}}, sample};
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
        acc_sum[k] = sum[DATA_WIDTH] ? AccMin : AccMax;
        sat_hit    = 1'b1;
      end else begin
        acc_sum[k] = sum[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    logits_d = logits_q;
    osat_d   = osat_q;
    unique case (state_q)
      StAccum: begin
        if (bus.i_clear) begin
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (bus.i_valid) begin
          if (cnt_q == LastStep) begin
            logits_d = acc_sum;
            osat_d   = sticky_q | sat_hit;
            state_d  = StHold;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
          end else begin
            acc_d    = acc_sum;
            cnt_d    = cnt_q + 1'b1;
            sticky_d = sticky_q | sat_hit;
          end
        end
      end
      StHold: begin
        if (bus.o_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      logits_q <= '0;
      osat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      logits_q <= logits_d;
      osat_q   <= osat_d;
    end
  end

  always_comb begin
    bus.i_ready  = (state_q == StAccum);
    bus.o_valid  = (state_q == StHold);
    bus.o_logits = logits_q;
    bus.o_sat    = osat_q;
  end

endmodule

// File: tb/tb_logit_accumulator.sv
// Directed bench: stimulus pushes expected frames, per-DUT monitors pop them on o_valid && o_ready.
module tb_logit_accumulator;

  typedef struct {
    int l0;
    int l1;
    int l2;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q32[$];
  exp_t q17[$];

  always #5 clk = ~clk;

  logit_accumulator_if #(.DATA_WIDTH(32), .IN_WIDTH(16)) b32 ();
  logit_accumulator_if #(.DATA_WIDTH(17), .IN_WIDTH(16)) b17 ();

  logit_accumulator #(.DATA_WIDTH(32), .IN_WIDTH(16), .NUM_STEPS(4)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  logit_accumulator #(.DATA_WIDTH(17), .IN_WIDTH(16), .NUM_STEPS(4)) u_dut17 (
    .clk (clk),
    .rst (rst),
    .bus (b17)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic exp_t mk(input int a, input int b, input int c, input bit s);
    exp_t e;
    e.l0 = a; e.l1 = b; e.l2 = c; e.sat = s;
    return e;
  endfunction

  // Monitors: one pop per handshake cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && b32.o_valid && b32.o_ready) begin
      if (q32.size() == 0) begin
        fail_now("unexpected_frame32");
      end else begin
        e = q32.pop_front();
        check("d32_logit0", longint'($signed(b32.o_logits[31:0])), e.l0);
        check("d32_logit1", longint'($signed(b32.o_logits[63:32])), e.l1);
        check("d32_logit2", longint'($signed(b32.o_logits[95:64])), e.l2);
        check("d32_sat", b32.o_sat, e.sat);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && b17.o_valid && b17.o_ready) begin
      if (q17.size() == 0) begin
        fail_now("unexpected_frame17");
      end else begin
        e = q17.pop_front();
        check("d17_logit0", longint'($signed(b17.o_logits[16:0])), e.l0);
        check("d17_logit1", longint'($signed(b17.o_logits[33:17])), e.l1);
        check("d17_logit2", longint'($signed(b17.o_logits[50:34])), e.l2);
        check("d17_sat", b17.o_sat, e.sat);
      end
    end
  end

  task automatic send32(input int a, input int b, input int c);
    int n = 0;
    b32.i_valid = 1'b1;
    b32.i_data  = {16'(c), 16'(b), 16'(a)};
    forever begin
      @(negedge clk);
      if (b32.i_ready) break;
      n++;
      if (n > 50) begin
        fail_now("send32_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    b32.i_valid = 1'b0;
  endtask

  task automatic send17(input int a, input int b, input int c);
    int n = 0;
    b17.i_valid = 1'b1;
    b17.i_data  = {16'(c), 16'(b), 16'(a)};
    forever begin
      @(negedge clk);
      if (b17.i_ready) break;
      n++;
      if (n > 50) begin
        fail_now("send17_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    b17.i_valid = 1'b0;
  endtask

  task automatic wait_idle32();
    int n = 0;
    @(negedge clk);
    while (!(b32.i_ready && q32.size() == 0)) begin
      n++;
      if (n > 40) begin
        fail_now("idle32_wait");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    b32.i_valid = 1'b0; b32.i_data = '0; b32.i_clear = 1'b0; b32.o_ready = 1'b1;
    b17.i_valid = 1'b0; b17.i_data = '0; b17.i_clear = 1'b0; b17.o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_i_ready", b32.i_ready, 1);
    check("rst_o_valid", b32.o_valid, 0);
    check("rst_o_logits", (b32.o_logits == '0) ? 0 : 1, 0);
    check("rst_o_sat", b32.o_sat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Saturation on a 17-bit accumulator, then a clean frame.
    q17.push_back(mk(65535, -65536, 4, 1'b1));
    repeat (4) send17(32767, -32768, 1);
    q17.push_back(mk(4, 4, 4, 1'b0));
    repeat (4) send17(1, 1, 1);

    // Basic frame with latency and i_ready timing.
    q32.push_back(mk(4, 8, 12, 1'b0));
    repeat (4) send32(1, 2, 3);
    @(negedge clk);
    check("basic_o_valid_next", b32.o_valid, 1);
    check("basic_i_ready_low", b32.i_ready, 0);
    @(negedge clk);
    check("basic_o_valid_drop", b32.o_valid, 0);
    check("basic_i_ready_back", b32.i_ready, 1);
    @(posedge clk);
    #1;

    q32.push_back(mk(-20, 0, 28, 1'b0));
    repeat (4) send32(-5, 0, 7);
    wait_idle32();

    // Backpressure: held frame must not move nor absorb beats.
    b32.o_ready = 1'b0;
    q32.push_back(mk(4, 4, 4, 1'b0));
    repeat (4) send32(1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      b32.i_valid = 1'b1;
      b32.i_data  = {16'(300 + i), 16'(200 + i), 16'(100 + i)};
      @(negedge clk);
      check("bp_o_valid", b32.o_valid, 1);
      check("bp_i_ready", b32.i_ready, 0);
      check("bp_logits_stable", (b32.o_logits == {32'd4, 32'd4, 32'd4}) ? 1 : 0, 1);
      @(posedge clk);
      #1;
    end
    b32.o_ready = 1'b1;
    b32.i_data  = {16'(5), 16'(5), 16'(5)};
    q32.push_back(mk(20, 20, 20, 1'b0));
    begin
      int n = 0;
      int guard = 0;
      while (n < 4) begin
        @(negedge clk);
        if (b32.i_ready) n++;
        guard++;
        @(posedge clk);
        #1;
        if (guard > 40) begin
          fail_now("bp_refill_wait");
          break;
        end
      end
    end
    b32.i_valid = 1'b0;
    wait_idle32();

    // Clear discards partial sums and the beat offered with it.
    q32.push_back(mk(4, 4, 4, 1'b0));
    repeat (2) send32(9, 9, 9);
    b32.i_clear = 1'b1;
    b32.i_valid = 1'b1;
    b32.i_data  = {16'(100), 16'(100), 16'(100)};
    @(posedge clk);
    #1;
    b32.i_clear = 1'b0;
    b32.i_valid = 1'b0;
    repeat (4) send32(1, 1, 1);
    wait_idle32();

    // Reset mid-frame drops the partial frame.
    repeat (3) send32(7, 7, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", b32.o_valid, 0);
    check("midrst_i_ready", b32.i_ready, 1);
    @(posedge clk);
    #1;
    q32.push_back(mk(8, 8, 8, 1'b0));
    repeat (4) send32(2, 2, 2);
    wait_idle32();

    // Reset while holding a frame.
    b32.o_ready = 1'b0;
    repeat (4) send32(3, 3, 3);
    @(negedge clk);
    check("hold_o_valid", b32.o_valid, 1);
    check("hold_logit0", longint'($signed(b32.o_logits[31:0])), 12);
    b32.i_clear = 1'b1;
    @(posedge clk);
    #1;
    b32.i_clear = 1'b0;
    @(negedge clk);
    check("hold_clear_ignored", b32.o_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("holdrst_o_valid", b32.o_valid, 0);
    check("holdrst_o_logits", (b32.o_logits == '0) ? 0 : 1, 0);
    check("holdrst_i_ready", b32.i_ready, 1);
    b32.o_ready = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check("q32_drained", q32.size(), 0);
    check("q17_drained", q17.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
